stream_window_3x3: RTL and testbench
====================================

# stream_window_3x3

Streaming 3x3 neighbourhood generator between the memory controller pixel stream and the filter core. It accepts one raster-order frame of IMG_H×IMG_W pixels with valid/ready flow control and emits exactly one 3x3 window per pixel ("same"-size output). Border windows use zero or replicate padding. A built-in flush drains the final row without further input. Output backpressure is supported, and frame, line and done markers are provided for the controller.

## Interface
- DATA_W, 8: pixel width in bits
- IMG_W, 540: pixels per row; ≥3
- IMG_H, 540: rows per frame; ≥2
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pad_mode_i  in  1  0 = zero pad, 1 = replicate pad; latched on first accepted pixel of a frame
- data_i  in  DATA_W  input pixel, raster order
- data_en_i  in  1  input valid
- data_rdy_o  out  1  input ready
- win_o  out  9*DATA_W  window; slice [(3*i+j)*DATA_W +: DATA_W] = pixel (r-1+i, c-1+j) for centre (r,c)
- win_valid_o  out  1  window valid
- win_ready_i  in  1  core accepts window
- sof_o  out  1  with window, centre (0,0)
- eol_o  out  1  with window, centre column IMG_W-1
- eof_o  out  1  with window, centre (IMG_H-1, IMG_W-1)
- done_o  out  1  one-cycle pulse after eof window handshake

## Operation
- Input transfer on data_en_i && data_rdy_o; output transfer on win_valid_o && win_ready_i.
- Single output register: data_rdy_o = (state ∈ {IDLE,FILL,RUN}) && (!win_valid_o || win_ready_i) && !rst.
- Storage: two IMG_W-deep line delays plus a 3x3 register array; pixel index k (raster, 0..IMG_H*IMG_W-1) shifts through all taps.
- Accepting pixel k produces the window centred on k-(IMG_W+1); uniform lag, including across row wrap (accepting (r+1,0) produces centre (r,IMG_W-1)).
- FSM:
  - IDLE: first accept → FILL; latch pad mode; clear counters.
  - FILL: first IMG_W+1 accepts produce no window; → RUN when the (IMG_W+1)th pixel is accepted (the IMG_W+2th accept emits centre (0,0)).
  - RUN: each accept emits one window; after pixel IMG_H*IMG_W-1 is accepted → FLUSH.
  - FLUSH: data_rdy_o=0. Inject IMG_W+1 dummy shifts (value 0), one per cycle when the output register is free. After the window with eof_o is handshaken → IDLE with done_o pulse.
- Centre counters row_c/col_c track emitted windows; widths $clog2(IMG_H), $clog2(IMG_W); col_c wraps at IMG_W-1, row_c increments on wrap.
- Padding, per tap (i,j), applied on output mux:
  - Zero mode: out-of-image taps (r-1<0, r+1>IMG_H-1, c-1<0, c+1>IMG_W-1) = 0.
  - Replicate mode: out-of-image row index clamps to r, column index clamps to c. Corners apply both clamps.
  - Taps wrapped from the previous row or from dummy flush data are never visible.
- Total windows per frame = IMG_H*IMG_W; no window dropped or duplicated under any backpressure pattern.
- Frames may be back-to-back: the next frame's first pixel is accepted in IDLE the cycle after done_o.

## Timing
- Reset: win_valid_o=0, win_o=0, sof_o/eol_o/eof_o=0, done_o=0, data_rdy_o=0 while rst; state=IDLE; counters=0; line delays need not be cleared.
- rst mid-frame: partial frame discarded; the next cycle after rst deasserts is IDLE with data_rdy_o=1.
- Latency: window registered; win_valid_o rises the cycle after the producing input (or flush) transfer.
- win_valid_o and win_o are held stable until handshake.
- Markers are aligned with their window and held with it.
- done_o is asserted the cycle after the eof handshake, for exactly 1 cycle.
- Full throughput: 1 pixel/cycle in, 1 window/cycle out with win_ready_i=1. Frame occupancy = IMG_H*IMG_W + IMG_W + 2 cycles.

## Structure
- Package stream_window_pkg: state_t enum {IDLE, FILL, RUN, FLUSH}; pad_mode_t enum {PAD_ZERO, PAD_REPL}; tap index constants.
- Sub-module line_delay (DATA_W, DEPTH): IMG_W-deep shift/circular-RAM delay with an enable; instantiated twice.
- The top level holds the FSM, tap array, pad mux, counters and output register.

## Test plan
All scenarios use IMG_W=4, IMG_H=3, pixel value = raster index.
- Zero pad, no stall, win_ready_i=1 → 12 windows. Centre (0,0) = {0,0,0, 0,0,1, 0,4,5}. Centre (1,1) = {0,1,2,4,5,6,8,9,10}. Centre (2,3) = {6,7,0,10,11,0,0,0,0}.
- Replicate pad, same stimulus:
  - Centre (0,0) = {0,0,1,0,0,1,4,4,5}.
  - Centre (2,3) = {6,7,7,10,11,11,10,11,11}.
  - sof_o on window 0, eol_o on windows 3/7/11, eof_o on window 11.
- Random win_ready_i (50%) and random data_en_i gaps → same 12 windows in order; win_o stable while stalled; data_rdy_o=0 throughout FLUSH.
- Two back-to-back frames (values +100 for frame 2) with pad mode toggled between them → done_o pulses once per frame; frame 2 windows use the new mode and never contain frame-1 pixels.
- rst asserted after 7 accepted pixels, then a full frame → no window from the aborted frame; the new frame matches scenario 1 exactly.
- Corner check: window count = 12 and done_o asserted exactly 1 cycle after the eof handshake.

Source files
------------

// File: rtl/stream_window_pkg.sv
// Shared types and tap indices for the 3x3 streaming window generator.
package stream_window_pkg;

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    typedef enum logic {PAD_ZERO, PAD_REPL} pad_mode_t;

    // Row/column position of a tap relative to the window centre.
    localparam int unsigned TAP_PREV = 0;
    localparam int unsigned TAP_MID  = 1;
    localparam int unsigned TAP_NEXT = 2;

endpackage

// File: rtl/stream_window_3x3_line_delay.sv
// Fixed-depth delay line built on a circular buffer; advances only when en is high.
module line_delay #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 540
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     ptr;

    // Read-before-write at the same slot gives exactly DEPTH enabled shifts of delay.
    assign dout = mem[ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/stream_window_3x3.sv
// Raster-order pixel stream to same-size 3x3 windows with zero/replicate border padding.
module stream_window_3x3
    import stream_window_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 540,
    parameter int unsigned IMG_H  = 540
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pad_mode_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_en_i,
    output logic              data_rdy_o,
    output logic [9*DATA_W-1:0] win_o,
    output logic              win_valid_o,
    input  logic              win_ready_i,
    output logic              sof_o,
    output logic              eol_o,
    output logic              eof_o,
    output logic              done_o
);

    localparam int unsigned NPIX = IMG_H * IMG_W;
    localparam int unsigned CW   = $clog2(IMG_W);
    localparam int unsigned RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int unsigned PW   = $clog2(NPIX);
    localparam int unsigned FW   = $clog2(IMG_W + 2);

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LEN  = FW'(IMG_W + 1);
    localparam logic [PW-1:0] FILL_LAST  = PW'(IMG_W);
    localparam logic [PW-1:0] FRAME_LAST = PW'(NPIX - 1);

    state_t    state, state_nxt;
    pad_mode_t pad_mode;

    logic [PW-1:0] pix_cnt;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] row_c;
    logic [CW-1:0] col_c;

    logic [DATA_W-1:0] taps [3][3];
    logic [DATA_W-1:0] sh   [3][3];
    logic [DATA_W-1:0] line1_out, line2_out, pix_in;
    logic [2:0]        row_oob, col_oob;
    logic [9*DATA_W-1:0] win_nxt;

    logic out_free, accept, flush_shift, shift, emit, eof_hs;

    assign out_free    = !win_valid_o || win_ready_i;
    assign data_rdy_o  = (state != FLUSH) && out_free && !rst;
    assign accept      = data_en_i && data_rdy_o;
    assign flush_shift = (state == FLUSH) && (flush_cnt != FLUSH_LEN) && out_free;
    assign shift       = accept || flush_shift;
    assign emit        = shift && ((state == RUN) || (state == FLUSH));
    assign eof_hs      = win_valid_o && win_ready_i && eof_o;
    assign pix_in      = (state == FLUSH) ? '0 : data_i;

    line_delay #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_line1 (
        .clk  (clk),
        .rst  (rst),
        .en   (shift),
        .din  (pix_in),
        .dout (line1_out)
    );

    line_delay #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_line2 (
        .clk  (clk),
        .rst  (rst),
        .en   (shift),
        .din  (line1_out),
        .dout (line2_out)
    );

    // Tap array as it will look after this cycle's shift; windows are built from it.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sh[i][0] = taps[i][1];
            sh[i][1] = taps[i][2];
        end
        sh[TAP_PREV][2] = line2_out;
        sh[TAP_MID][2]  = line1_out;
        sh[TAP_NEXT][2] = pix_in;
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            taps <= sh;
        end
    end

    always_comb begin
        row_oob           = '0;
        col_oob           = '0;
        row_oob[TAP_PREV] = (row_c == '0);
        row_oob[TAP_NEXT] = (row_c == ROW_LAST);
        col_oob[TAP_PREV] = (col_c == '0);
        col_oob[TAP_NEXT] = (col_c == COL_LAST);
    end

    // Out-of-image taps hold wrapped-row or flush data; they are replaced, never shown.
    always_comb begin
        win_nxt = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (pad_mode == PAD_REPL) begin
                    win_nxt[(3*i+j)*DATA_W +: DATA_W] =
                        sh[row_oob[i] ? TAP_MID : i][col_oob[j] ? TAP_MID : j];
                end else if (!row_oob[i] && !col_oob[j]) begin
                    win_nxt[(3*i+j)*DATA_W +: DATA_W] = sh[i][j];
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = FILL;
            FILL:  if (accept && pix_cnt == FILL_LAST) state_nxt = RUN;
            RUN:   if (accept && pix_cnt == FRAME_LAST) state_nxt = FLUSH;
            FLUSH: if (eof_hs) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pad_mode    <= PAD_ZERO;
            pix_cnt     <= '0;
            flush_cnt   <= '0;
            row_c       <= '0;
            col_c       <= '0;
            win_o       <= '0;
            win_valid_o <= 1'b0;
            sof_o       <= 1'b0;
            eol_o       <= 1'b0;
            eof_o       <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_o <= eof_hs;

            if (accept) begin
                if (state == IDLE) begin
                    pad_mode <= pad_mode_t'(pad_mode_i);
                    pix_cnt  <= PW'(1);
                    row_c    <= '0;
                    col_c    <= '0;
                end else begin
                    pix_cnt <= pix_cnt + 1'b1;
                end
            end

            if (state == RUN && state_nxt == FLUSH) begin
                flush_cnt <= '0;
            end else if (flush_shift) begin
                flush_cnt <= flush_cnt + 1'b1;
            end

            if (emit) begin
                win_o       <= win_nxt;
                win_valid_o <= 1'b1;
                sof_o       <= (row_c == '0) && (col_c == '0);
                eol_o       <= (col_c == COL_LAST);
                eof_o       <= (col_c == COL_LAST) && (row_c == ROW_LAST);
                if (col_c == COL_LAST) begin
                    col_c <= '0;
                    row_c <= (row_c == ROW_LAST) ? '0 : row_c + 1'b1;
                end else begin
                    col_c <= col_c + 1'b1;
                end
            end else if (win_ready_i) begin
                win_valid_o <= 1'b0;
                sof_o       <= 1'b0;
                eol_o       <= 1'b0;
                eof_o       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_window_3x3.sv
// Scoreboard bench for stream_window_3x3 on a 4x3 frame with pixel value = raster index.
module tb_stream_window_3x3;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int NPIX  = W * H;
    localparam int DW    = 8;
    localparam int WIN_W = 9 * DW;

    typedef struct {
        logic [WIN_W-1:0] win;
        bit               sof;
        bit               eol;
        bit               eof;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             pad_mode_i;
    logic [DW-1:0]    data_i;
    logic             data_en_i;
    logic             data_rdy_o;
    logic [WIN_W-1:0] win_o;
    logic             win_valid_o;
    logic             win_ready_i;
    logic             sof_o, eol_o, eof_o, done_o;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   win_total  = 0;
    int   done_total = 0;
    bit   discard    = 0;
    bit   rand_ready = 0;

    always #5 clk = ~clk;

    stream_window_3x3 #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pad_mode_i  (pad_mode_i),
        .data_i      (data_i),
        .data_en_i   (data_en_i),
        .data_rdy_o  (data_rdy_o),
        .win_o       (win_o),
        .win_valid_o (win_valid_o),
        .win_ready_i (win_ready_i),
        .sof_o       (sof_o),
        .eol_o       (eol_o),
        .eof_o       (eof_o),
        .done_o      (done_o)
    );

    task automatic check(input string tag, input logic [WIN_W-1:0] got,
                         input logic [WIN_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference window built directly from image coordinates.
    function automatic exp_t mk(input int base, input bit repl, input int idx);
        exp_t e;
        int   r, c, rr, cc;
        bit   oob;
        r = idx / W;
        c = idx % W;
        e.win = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rr  = r - 1 + i;
                cc  = c - 1 + j;
                oob = 0;
                if (rr < 0 || rr > H - 1) begin oob = 1; rr = r; end
                if (cc < 0 || cc > W - 1) begin oob = 1; cc = c; end
                if (!oob || repl) e.win[(3*i+j)*DW +: DW] = DW'(base + rr * W + cc);
            end
        end
        e.sof = (idx == 0);
        e.eol = (c == W - 1);
        e.eof = (idx == NPIX - 1);
        return e;
    endfunction

    task automatic monitor();
        exp_t e;
        bit   done_exp = 0;
        bit   rst_prev = 1;
        bit   flushing = 0;
        int   pix_seen = 0;
        forever begin
            @(negedge clk);
            check("done", done_o, done_exp);
            done_exp = 0;
            if (done_o) done_total++;
            if (rst) begin
                if (rst_prev) begin
                    check("rst_valid", win_valid_o, 0);
                    check("rst_win", win_o, 0);
                    check("rst_rdy", data_rdy_o, 0);
                    check("rst_marks", {sof_o, eol_o, eof_o}, 0);
                end
                flushing = 0;
                pix_seen = 0;
                rst_prev = 1;
                continue;
            end
            rst_prev = 0;
            if (flushing) check("rdy_flush", data_rdy_o, 0);
            if (data_en_i && data_rdy_o) begin
                pix_seen++;
                if (pix_seen == NPIX) begin
                    flushing = 1;
                    pix_seen = 0;
                end
            end
            if (win_valid_o && !discard) begin
                if (exp_q.size() == 0) begin
                    check("extra_window", win_valid_o, 0);
                end else begin
                    e = exp_q[0];
                    if (win_ready_i) check("win", win_o, e.win);
                    else             check("win_hold", win_o, e.win);
                    check("sof", sof_o, e.sof);
                    check("eol", eol_o, e.eol);
                    check("eof", eof_o, e.eof);
                    if (win_ready_i) begin
                        void'(exp_q.pop_front());
                        win_total++;
                        if (e.eof) begin
                            done_exp = 1;
                            flushing = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic ready_gen();
        forever begin
            @(posedge clk);
            #1;
            win_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    // Pad mode is flipped after the first pixel to confirm it is latched per frame.
    task automatic send_frame(input int base, input bit repl, input bit gaps,
                              input bit push, input int npix);
        bit acc;
        for (int k = 0; k < npix; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    data_en_i = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            data_en_i  = 1'b1;
            data_i     = DW'(base + k);
            pad_mode_i = (k == 0) ? repl : !repl;
            acc = 0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = data_rdy_o;
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                check("accept_timeout", acc, 1);
                data_en_i = 1'b0;
                return;
            end
            if (push) begin
                if (k >= W + 1) exp_q.push_back(mk(base, repl, k - W - 1));
                if (k == NPIX - 1) begin
                    for (int c = NPIX - W - 1; c < NPIX; c++) exp_q.push_back(mk(base, repl, c));
                end
            end
        end
        data_en_i = 1'b0;
    endtask

    task automatic run_frame(input int base, input bit repl, input bit gaps);
        int w0, d0;
        bit seen;
        w0   = win_total;
        d0   = done_total;
        seen = 0;
        send_frame(base, repl, gaps, 1, NPIX);
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            seen = done_o;
        end
        @(posedge clk);
        #1;
        check("done_seen", seen, 1);
        check("win_count", win_total - w0, NPIX);
        check("done_count", done_total - d0, 1);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        pad_mode_i  = 1'b0;
        data_i      = '0;
        data_en_i   = 1'b0;
        win_ready_i = 1'b1;
        @(posedge clk);
        fork
            monitor();
            ready_gen();
        join_none
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_rdy", data_rdy_o, 1);
        @(posedge clk);
        #1;

        run_frame(0, 0, 0);
        run_frame(0, 1, 0);

        rand_ready = 1;
        run_frame(0, 0, 1);
        run_frame(0, 1, 1);
        rand_ready = 0;

        run_frame(0, 1, 0);
        run_frame(100, 0, 0);

        discard = 1;
        send_frame(0, 0, 0, 0, 7);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        discard = 0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_exit_rdy", data_rdy_o, 1);
        @(posedge clk);
        #1;
        run_frame(0, 0, 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
